mem_access_unit: RTL and testbench

Load/store front end placed between the EX/MEM pipeline register and the word-indexed data memory. It converts byte addresses to word indices and performs byte/halfword loads with sign or zero extension. Sub-word stores run as a two-cycle read-modify-write, and the unit stalls the pipeline while one is in progress. It also rejects out-of-range, misaligned and malformed requests before they reach the memory.

---
 rtl/mips_mem_pkg.sv | 15 +
 rtl/mem_lane_align.sv | 43 ++++
 rtl/mem_access_unit.sv | 117 +++++++++++
 tb/tb_mem_access_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the load/store front end: access sizes, FSM states, default depth.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int MAU_DEPTH = 32;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } mau_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Lane extract/extend for loads and lane insert for stores; purely combinational.
// Little-endian lanes: bytes by offset[1:0], halfwords by offset[1] only.
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [4:0]  byte_sh;

    assign byte_sh = {offset, 3'b000};
    assign byte_v  = rdata[byte_sh +: 8];
    assign half_v  = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_val = rdata;
        merged   = wdata;
        case (size)
            SZ_BYTE: begin
                load_val = {{24{~is_unsigned & byte_v[7]}}, byte_v};
                merged   = rdata;
                merged[byte_sh +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_val = {{16{~is_unsigned & half_v[15]}}, half_v};
                merged   = offset[1] ? {wdata[15:0], rdata[15:0]} : {rdata[31:16], wdata[15:0]};
            end
            default: begin
                load_val = rdata;
                merged   = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end: byte address to word index, extended loads, RMW sub-word stores.
// Optional misalignment trapping is enabled by defining MAU_MISALIGN_TRAP_EN.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = MAU_DEPTH
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        LOAD,
    input  logic        STORE,
    input  logic [1:0]  SIZE,
    input  logic        UNSIGNED,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic        STALL,
    output logic [31:0] LOAD_DATA,
    output logic        LOAD_VALID,
    output logic        ERR,
    output logic        MEM_ENABLE,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA
);

    localparam logic [0:0] IDLE  = ST_IDLE;
    localparam logic [0:0] WRITE = ST_WRITE;

    logic [0:0]  state;
    logic [29:0] wr_idx;
    logic [31:0] wr_word;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic        in_range;
    logic        misalign;
    logic        illegal;
    logic        idle;
    logic        accept;
    logic        reject;
    logic        do_load;
    logic        do_wstore;
    logic        do_sub;
    logic        in_write;

    assign in_range = ({2'b00, ADDR[31:2]} < 32'(DEPTH));

`ifdef MAU_MISALIGN_TRAP_EN
    assign misalign = ((SIZE == SZ_HALF) && ADDR[0]) || ((SIZE == SZ_WORD) && (ADDR[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign illegal = (LOAD & STORE) | (SIZE == 2'b11) | ~in_range | misalign;

    // While in WRITE the held store request on the inputs is ignored.
    assign idle      = (state == IDLE);
    assign accept    = REQ & idle & ~illegal & ~RESET;
    assign reject    = REQ & idle & illegal;
    assign do_load   = accept & LOAD;
    assign do_wstore = accept & STORE & (SIZE == SZ_WORD);
    assign do_sub    = accept & STORE & (SIZE != SZ_WORD);
    assign in_write  = (state == WRITE) & ~RESET;

    mem_lane_align u_align (
        .size        (SIZE),
        .offset      (ADDR[1:0]),
        .is_unsigned (UNSIGNED),
        .rdata       (MEM_RDATA),
        .wdata       (WDATA),
        .load_val    (load_val),
        .merged      (merged)
    );

    always_comb begin
        STALL      = do_sub;
        MEM_ENABLE = do_load | do_wstore | in_write;
        MEM_READ   = do_load | do_sub;
        MEM_WRITE  = do_wstore | in_write;
        MEM_ADDR   = 32'h0;
        MEM_WDATA  = 32'h0;
        if (in_write) begin
            MEM_ADDR  = {2'b00, wr_idx};
            MEM_WDATA = wr_word;
        end else if (do_load | do_wstore | do_sub) begin
            MEM_ADDR  = {2'b00, ADDR[31:2]};
            MEM_WDATA = do_wstore ? WDATA : 32'h0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            wr_idx     <= '0;
            wr_word    <= '0;
            LOAD_DATA  <= '0;
            LOAD_VALID <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            LOAD_VALID <= do_load;
            ERR        <= reject;
            if (do_load) begin
                LOAD_DATA <= load_val;
            end
            if (do_sub) begin
                wr_word <= merged;
                wr_idx  <= ADDR[31:2];
                state   <= WRITE;
            end else if (state == WRITE) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-indexed memory model and load scoreboard.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ;
    logic        LOAD;
    logic        STORE;
    logic [1:0]  SIZE;
    logic        UNSIGNED;
    logic [31:0] ADDR;
    logic [31:0] WDATA;
    logic        STALL;
    logic [31:0] LOAD_DATA;
    logic        LOAD_VALID;
    logic        ERR;
    logic        MEM_ENABLE;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;

    logic [31:0] mem [0:31] = '{default: 32'h0};
    logic [31:0] sb [$];
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    assign MEM_RDATA = (MEM_ADDR < 32) ? mem[MEM_ADDR[4:0]] : 32'h0;

    always @(negedge CLK) begin
        if (MEM_ENABLE && MEM_WRITE && MEM_ADDR < 32)
            mem[MEM_ADDR[4:0]] <= MEM_WDATA;
    end

    mem_access_unit dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ        (REQ),
        .LOAD       (LOAD),
        .STORE      (STORE),
        .SIZE       (SIZE),
        .UNSIGNED   (UNSIGNED),
        .ADDR       (ADDR),
        .WDATA      (WDATA),
        .STALL      (STALL),
        .LOAD_DATA  (LOAD_DATA),
        .LOAD_VALID (LOAD_VALID),
        .ERR        (ERR),
        .MEM_ENABLE (MEM_ENABLE),
        .MEM_READ   (MEM_READ),
        .MEM_WRITE  (MEM_WRITE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_RDATA  (MEM_RDATA)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic req, input logic ld, input logic st, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        REQ = req; LOAD = ld; STORE = st; SIZE = sz; UNSIGNED = uns; ADDR = addr; WDATA = wd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    endtask

    // Advance one cycle; LOAD_VALID must match whether a load was pending, then pop its result.
    task automatic tick();
        logic [31:0] e;
        logic        pend;
        @(posedge CLK);
        #1;
        pend = (sb.size() != 0);
        check("load_valid", {31'h0, LOAD_VALID}, {31'h0, pend});
        if (pend) begin
            e = sb.pop_front();
            check("load_data", LOAD_DATA, e);
        end
    endtask

    task automatic word_store(input logic [31:0] addr, input logic [31:0] wd);
        drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, addr, wd);
        #1;
        check("wst_stall", {31'h0, STALL}, 32'h0);
        check("wst_write", {31'h0, MEM_WRITE}, 32'h1);
        tick();
        idle();
    endtask

    initial begin
        idle();
        RESET = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        #12;
        check("rst_stall", {31'h0, STALL}, 32'h0);
        check("rst_mem_read", {31'h0, MEM_READ}, 32'h0);
        check("rst_mem_en", {31'h0, MEM_ENABLE}, 32'h0);
        check("rst_lvalid", {31'h0, LOAD_VALID}, 32'h0);
        check("rst_err", {31'h0, ERR}, 32'h0);
        check("rst_ldata", LOAD_DATA, 32'h0);
        idle();
        @(posedge CLK); #1;
        RESET = 1'b0;

        word_store(32'h0, 32'h12345678);
        word_store(32'h4, 32'h11223344);
        word_store(32'h8, 32'h55667788);
        check("init_mem1", mem[1], 32'h11223344);

        // Byte store 0xAB at 0x5.
        drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h5, 32'h000000AB);
        #1;
        check("sb_stall1", {31'h0, STALL}, 32'h1);
        check("sb_read1", {31'h0, MEM_READ}, 32'h1);
        check("sb_write1", {31'h0, MEM_WRITE}, 32'h0);
        tick();
        check("sb_stall2", {31'h0, STALL}, 32'h0);
        check("sb_write2", {31'h0, MEM_WRITE}, 32'h1);
        check("sb_addr2", MEM_ADDR, 32'h1);
        tick();
        idle();
        check("sb_mem", mem[1], 32'h1122AB44);

        word_store(32'h4, 32'h80FF0000);
        check("wst_mem", mem[1], 32'h80FF0000);

        drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h6, 32'h0);
        sb.push_back(32'hFFFFFFFF);
        tick();
        drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h6, 32'h0);
        sb.push_back(32'h000000FF);
        tick();

        // Halfword store then immediate load of the same word.
        drive(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h2, 32'h0000BEEF);
        tick();
        tick();
        drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h2, 32'h0);
        sb.push_back(32'h0000BEEF);
        tick();
        drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
        sb.push_back(32'hFFFFBEEF);
        tick();
        idle();
        check("sh_mem", mem[0], 32'hBEEF5678);

        // Out-of-range word store.
        drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h80, 32'hDEADBEEF);
        #1;
        check("oor_write", {31'h0, MEM_WRITE}, 32'h0);
        check("oor_stall", {31'h0, STALL}, 32'h0);
        tick();
        idle();
        check("oor_err", {31'h0, ERR}, 32'h1);
        check("oor_mem0", mem[0], 32'hBEEF5678);
        tick();
        check("err_drop", {31'h0, ERR}, 32'h0);

        drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h4, 32'h0);
        #1;
        check("ls_mem_en", {31'h0, MEM_ENABLE}, 32'h0);
        tick();
        idle();
        check("ls_err", {31'h0, ERR}, 32'h1);

        drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h4, 32'h0);
        tick();
        idle();
        check("sz11_err", {31'h0, ERR}, 32'h1);

        // Misaligned word load.
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h3, 32'h0);
`ifdef MAU_MISALIGN_TRAP_EN
        tick();
        idle();
        check("mis_err", {31'h0, ERR}, 32'h1);
`else
        sb.push_back(32'hBEEF5678);
        tick();
        idle();
        check("mis_err", {31'h0, ERR}, 32'h0);
`endif

        // Reset during the WRITE cycle of a byte store.
        drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h8, 32'h00000099);
        tick();
        RESET = 1'b1;
        #1;
        check("rw_write", {31'h0, MEM_WRITE}, 32'h0);
        check("rw_stall", {31'h0, STALL}, 32'h0);
        #5;
        check("rw_mem", mem[2], 32'h55667788);
        check("rw_err", {31'h0, ERR}, 32'h0);
        idle();
        @(posedge CLK); #1;
        RESET = 1'b0;
        tick();
        check("rw_err2", {31'h0, ERR}, 32'h0);

        // No request: no access, no pulses.
        idle();
        #1;
        check("idle_mem_en", {31'h0, MEM_ENABLE}, 32'h0);
        tick();
        check("idle_err", {31'h0, ERR}, 32'h0);

        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        sb.push_back(32'h55667788);
        tick();
        idle();
        tick();
        check("sb_empty", sb.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
